clk_rate_meter: RTL and testbench
=================================

// Module: clk_rate_meter
// PURPOSE
//   Measures the period of a slow, possibly asynchronous square wave (slow clock, tap/MIDI tempo) in
//   100MHz clk cycles. It is the receive side of our slow-clock generators.
//   Synchronises sig_in, emits a one-cycle tick per rising edge and reports each full period.
//   Flags lock when consecutive periods agree, and times out when the input stops toggling.
// PARAMETERS
//   CNT_W        27           width of period counter/output; must hold TIMEOUT
//   TIMEOUT      125_000_000  max clk cycles between rising edges before timeout (>=2)
//   TOL          16           max |period - prev_period| still counted as agreement
//   SYNC_STAGES  2            synchroniser flops on sig_in (>=2)
// PORTS
//   clk           in   1      100MHz reference clock
//   rst           in   1      synchronous, active-high reset
//   sig_in        in   1      asynchronous slow input to be measured
//   tick          out  1      one-cycle pulse per detected rising edge of sig_in
//   period        out  CNT_W  last measured period in clk cycles; 0 until first valid
//   period_valid  out  1      one-cycle pulse when period updates
//   locked        out  1      level: last two periods within TOL
//   timeout       out  1      one-cycle pulse when TIMEOUT elapses with no edge
// BEHAVIOUR
//   Reset (sync, rst=1 at a clk edge): sync chain, edge flop, cnt, prev_period, period <= 0;
//     tick, period_valid, locked, timeout <= 0; FSM <= IDLE. rst dominates all other events.
//   Sync/edge: SYNC_STAGES-flop chain -> s; s_d <= s; rise = s & ~s_d.
//     tick is registered: if clk edge k is first to sample sig_in=1, tick=1 for the single cycle
//     after edge k+SYNC_STAGES. No debounce: any pulse sampled high for >=1 edge counts.
//     Chain resets to 0, so sig_in held high across reset release yields one tick after release.
//   FSM states: IDLE (no reference edge), MEASURE (counting since last edge).
//   IDLE: cnt held 0. On rise -> MEASURE, cnt <= 0, tick only (no period_valid).
//   MEASURE, each cycle without rise: cnt <= cnt+1.
//   MEASURE on rise: period <= cnt+1 (exact edge-to-edge cycles), period_valid <= 1, cnt <= 0.
//     prev_period <= new period.
//     locked <= (prev_period!=0) && |new - prev_period| <= TOL; computed unsigned, no wrap.
//   Timeout: in MEASURE, cnt == TIMEOUT-1 and no rise in that cycle -> IDLE,
//     timeout <= 1 for one cycle, locked <= 0, period <= 0, prev_period <= 0, cnt <= 0.
//   Simultaneous: rise in the cycle cnt == TIMEOUT-1 -> rise wins, period = TIMEOUT, no timeout.
//   Max reportable period = TIMEOUT; cnt never exceeds TIMEOUT-1, no counter wrap possible.
//   Latency: period/period_valid assert in the same cycle as the corresponding tick.
//   period holds its value between updates; period_valid, tick and timeout are never high >1 cycle.
//   locked changes only on a rise in MEASURE, on timeout, or on reset.
// TESTING  (bench overrides TIMEOUT=1000, TOL=2, SYNC_STAGES=2)
//   rst high 3 cycles, sig_in=0 -> all outputs 0; no tick for 50 cycles after release.
//   sig_in square, period 100 -> rise1: tick only.
//     rise2: period=100, period_valid, locked=0. rise3: period=100, locked=1.
//   periods 100,101,104 -> locked=1 after the 101 measurement; locked=0 after the 104 measurement.
//   locked at 100, then sig_in stuck 0 -> timeout pulse 1000 cycles after last rise.
//     Same cycle: locked=0, period=0. Next rise gives tick, no period_valid.
//   rise exactly 1000 cycles after previous rise -> period=1000, period_valid=1, timeout never asserts.
//   rst pulsed mid-measurement with sig_in held 1 -> all outputs 0 during reset.
//     Exactly one tick arrives 2 cycles after release, then no period_valid until the next rise.

Source files
------------

// File: rtl/clk_rate_meter.sv
// rtl/clk_rate_meter.sv - period, lock and timeout meter for a slow asynchronous square wave
module clk_rate_meter #(
    parameter int CNT_W       = 27,
    parameter int TIMEOUT     = 125_000_000,
    parameter int TOL         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0]       prev_period, prev_nxt;
    logic [CNT_W-1:0]       period_nxt;
    logic                   locked_nxt, pv_nxt, to_nxt;
    logic [CNT_W-1:0]       new_period, diff;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    // Metastability chain plus delayed copy for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    // Edge-to-edge cycle count is cnt+1 because cnt restarts at 0 on the edge cycle
    assign new_period = cnt + CNT_ONE;
    assign diff       = (new_period >= prev_period) ? (new_period - prev_period)
                                                    : (prev_period - new_period);

    // Next-state and next-output logic; a rise on the last count wins over the timeout
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        period_nxt = period;
        prev_nxt   = prev_period;
        locked_nxt = locked;
        pv_nxt     = 1'b0;
        to_nxt     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_nxt = new_period;
                    pv_nxt     = 1'b1;
                    cnt_nxt    = '0;
                    prev_nxt   = new_period;
                    locked_nxt = (prev_period != '0) && (diff <= TOL_C);
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = IDLE;
                    to_nxt     = 1'b1;
                    locked_nxt = 1'b0;
                    period_nxt = '0;
                    prev_nxt   = '0;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            prev_period  <= '0;
            period       <= '0;
            tick         <= 1'b0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            prev_period  <= prev_nxt;
            period       <= period_nxt;
            tick         <= rise;
            period_valid <= pv_nxt;
            locked       <= locked_nxt;
            timeout      <= to_nxt;
        end
    end

endmodule

// File: tb/tb_clk_rate_meter.sv
// tb/tb_clk_rate_meter.sv - scoreboard bench for clk_rate_meter
`timescale 1ns/1ps
module tb_clk_rate_meter;

    localparam int CW      = 16;
    localparam int TIMEOUT = 1000;
    localparam int TOL     = 2;
    localparam int SS      = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig_in = 1'b0;
    logic          tick, period_valid, locked, timeout;
    logic [CW-1:0] period;

    clk_rate_meter #(
        .CNT_W(CW), .TIMEOUT(TIMEOUT), .TOL(TOL), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .tick(tick), .period(period),
        .period_valid(period_valid), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        logic [2:0] kind;   // {timeout, tick, period_valid}
        int       period;
        logic     locked;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    logic m_ref = 1'b0;
    int   m_last = 0;
    int   m_prev = 0;
    int   m_period = 0;
    logic m_locked = 1'b0;
    int   last_drive = 0;

    function automatic exp_t mk(input int c, input logic [2:0] k, input int p, input logic l);
        exp_t e;
        e.cyc = c; e.kind = k; e.period = p; e.locked = l;
        return e;
    endfunction

    // A reference edge with no later rise within TIMEOUT cycles produces a timeout
    task automatic model_gap(input int t);
        if (m_ref && (t - m_last > TIMEOUT)) begin
            q.push_back(mk(m_last + TIMEOUT + SS, 3'b100, 0, 1'b0));
            m_ref = 1'b0; m_prev = 0; m_period = 0; m_locked = 1'b0;
        end
    endtask

    // t is the clk edge that first samples sig_in high
    task automatic model_rise(input int t);
        int newp, d;
        model_gap(t);
        if (!m_ref) begin
            q.push_back(mk(t + SS, 3'b010, m_period, m_locked));
            m_ref = 1'b1;
        end else begin
            newp = t - m_last;
            d = (newp > m_prev) ? newp - m_prev : m_prev - newp;
            m_locked = (m_prev != 0) && (d <= TOL);
            m_prev = newp;
            m_period = newp;
            q.push_back(mk(t + SS, 3'b011, newp, m_locked));
        end
        m_last = t;
    endtask

    // Called at a negedge; sig_in rises so it is first sampled gap cycles after the previous rise
    task automatic send_rise(input int gap);
        int target;
        target = last_drive + gap;
        model_rise(target);
        while (cyc < target - 1) begin
            @(negedge clk);
            if (cyc >= last_drive + gap / 2) sig_in = 1'b0;
        end
        sig_in = 1'b1;
        last_drive = target;
    endtask

    task automatic idle_for(input int gap);
        int target;
        target = last_drive + gap;
        model_gap(target);
        while (cyc < target) begin
            @(negedge clk);
            if (cyc >= last_drive + 50) sig_in = 1'b0;
        end
        last_drive = target;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tick"}, tick, 0);
        check_eq({tag, "_period"}, period, 0);
        check_eq({tag, "_period_valid"}, period_valid, 0);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_timeout"}, timeout, 0);
    endtask

    // Scoreboard: every output event must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] k;
        if (!rst && (tick || timeout || period_valid)) begin
            k = {timeout, tick, period_valid};
            if (q.size() == 0) begin
                check_eq("unexpected_event", k, 0);
            end else begin
                e = q.pop_front();
                check_eq("event_kind", k, e.kind);
                check_eq("event_cycle", cyc, e.cyc);
                check_eq("event_period", period, e.period);
                check_eq("event_locked", locked, e.locked);
            end
        end
    end

    initial begin
        int r;
        int budget;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (50) @(negedge clk);
        last_drive = cyc;

        send_rise(1);
        send_rise(100);
        send_rise(100);
        send_rise(101);
        send_rise(104);
        send_rise(100);
        send_rise(100);
        idle_for(1500);
        send_rise(200);
        send_rise(TIMEOUT);
        send_rise(TIMEOUT - 1);
        send_rise(TIMEOUT + 1);
        send_rise(500);
        send_rise(300);
        send_rise(300);

        // Reset mid-measurement with sig_in held high
        r = last_drive;
        while (cyc < r + 10) @(negedge clk);
        rst = 1'b1;
        m_ref = 1'b0; m_prev = 0; m_period = 0; m_locked = 1'b0;
        while (cyc < r + 13) @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        model_rise(r + 14);
        last_drive = r + 14;

        send_rise(300);
        idle_for(1100);

        budget = 0;
        while (q.size() != 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check_eq("queue_drained", q.size(), 0);
        check_eq("final_period", period, 0);
        check_eq("final_locked", locked, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
